logic_func_sweeper: RTL

Parametrised, registered truth-table engine for N-input Boolean functions. A function is loaded as a 2^N-bit minterm mask and can be used in two ways. It evaluates continuously against a live input vector. It can also be swept through every input combination, streaming the truth table and counting SOP minterms. This gives the gate-level function labs a generic, self-checking evaluator to compare hand-built DeMorgan/SOP/POS networks against.

---
 rtl/logic_func_sweeper.sv | 126 ++++++++++++
 1 files changed

// File: rtl/logic_func_sweeper.sv
// logic_func_sweeper: registered truth-table engine for an N_IN-input Boolean
// function. The loaded minterm mask is evaluated every cycle against in_vec.
// It can also be swept through all 2^N_IN minterms, streaming the truth table
// and counting the 1-minterms.
// Optional feature macro: LFS_POS_COUNT_EN adds the pos_terms (0-maxterm count) port.
module logic_func_sweeper #(
    parameter int N_IN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [2**N_IN-1:0]   load_data,
    input  logic [N_IN-1:0]      in_vec,
    output logic                 y,
    input  logic                 start,
    output logic                 busy,
    output logic                 sweep_valid,
    output logic [N_IN-1:0]      sweep_idx,
    output logic                 sweep_y,
    output logic                 done,
    output logic [N_IN:0]        sop_terms
`ifdef LFS_POS_COUNT_EN
    ,
    output logic [N_IN:0]        pos_terms
`endif
);

    localparam int              SIZE     = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(SIZE - 1);
`ifdef LFS_POS_COUNT_EN
    localparam logic [N_IN:0]   FULL_CNT = (N_IN+1)'(SIZE);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t             state;
    logic [SIZE-1:0]    tbl;
    logic [N_IN-1:0]    idx;
    logic [N_IN:0]      acc;
    logic               load_fire;

    // Loads are only taken while idle, so the table is stable for a whole sweep.
    assign load_ready = (state == IDLE);
    assign load_fire  = load_valid && load_ready;

    // Truth-table storage; replaced only on an accepted load.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
        end else if (load_fire) begin
            tbl <= load_data;
        end
    end

    // Live evaluation; reads the table as it was before any same-edge load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= 1'b0;
        end else begin
            y <= tbl[in_vec];
        end
    end

    // Sweep controller: steps through every minterm, then publishes the counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_idx   <= '0;
            sweep_y     <= 1'b0;
            done        <= 1'b0;
            sop_terms   <= '0;
`ifdef LFS_POS_COUNT_EN
            pos_terms   <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A load in the same cycle wins; that start is dropped.
                    if (start && !load_fire) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                SWEEP: begin
                    sweep_valid <= 1'b1;
                    sweep_idx   <= idx;
                    sweep_y     <= tbl[idx];
                    acc         <= acc + {{N_IN{1'b0}}, tbl[idx]};
                    // Terminal index is compared explicitly rather than relying on wrap.
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    sweep_valid <= 1'b0;
                    done        <= 1'b1;
                    sop_terms   <= acc;
`ifdef LFS_POS_COUNT_EN
                    pos_terms   <= FULL_CNT - acc;
`endif
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
